unidade_controle: RTL and testbench
===================================

# unidade_controle

Multi-cycle control unit that drives the 16×16 register bank (`memoria`) from the initiator side. It accepts 16-bit instructions over a valid/ready handshake. For each instruction it issues the two asynchronous read addresses, latches the returned operands, and computes the result in an internal ALU. It then performs the synchronous write-back through the bank's `enable`/`endereco_escrita`/`conteudo_escrita` port.

## Interface
Parameters: none. Width 16, 16 registers and 4-bit addresses are fixed to match the bank.

- clk  input  1  system clock, rising-edge
- rst  input  1  reset, asynchronous, active-high
- instr_valid  input  1  `instrucao` holds a valid instruction
- instrucao  input  16  instruction word: [15:12] opcode, [11:8] dest, [7:4] src1, [3:0] src2/imm4
- instr_ready  output  1  unit is idle and can accept an instruction
- endereco_reg1  output  4  bank read address 1
- endereco_reg2  output  4  bank read address 2
- conteudo_reg1  input  16  bank read data 1 (asynchronous)
- conteudo_reg2  input  16  bank read data 2 (asynchronous)
- enable  output  1  bank write enable
- endereco_escrita  output  4  bank write address
- conteudo_escrita  output  16  bank write data
- concluido  output  1  one-cycle pulse when an instruction retires
- erro  output  1  one-cycle pulse when an illegal opcode retires
- instr_executadas  output  8  count of retired instructions, wraps

## Operation
- FSM states: OCIOSO → DECODIFICA → EXECUTA → ESCREVE → OCIOSO. There are no other transitions.
- OCIOSO
  - `instr_ready=1`.
  - On an edge where `instr_valid&&instr_ready`, the unit registers `instrucao` into `ir` and moves to DECODIFICA.
  - Otherwise it stays in OCIOSO.
- DECODIFICA
  - `endereco_reg1=ir[7:4]` and `endereco_reg2=ir[3:0]`.
  - At the edge, the unit latches `conteudo_reg1` into `op_a` and `conteudo_reg2` into `op_b`.
- EXECUTA
  - The ALU computes from `op_a`, `op_b` and `ir`.
  - At the edge, the unit registers `resultado` and the `escreve`/`ilegal` flags.
- ESCREVE
  - `enable=escreve`, `endereco_escrita=ir[11:8]`, `conteudo_escrita=resultado`.
  - `concluido=1` and `erro=ilegal`.
  - At the edge, `instr_executadas` increments and the state returns to OCIOSO.
- Opcodes. Arithmetic is modulo 2^16, carries are discarded, and imm4 and imm8 are zero-extended.
  - 0000 NOP: no write.
  - 0001 ADD: a+b.
  - 0010 SUB: a−b.
  - 0011 AND.
  - 0100 OR.
  - 0101 XOR.
  - 0110 LDI: {8'h00, ir[7:0]}.
  - 0111 ADDI: a+imm4.
  - 1000 SHL: a<<imm4.
  - 1001 SHR: a>>imm4, logical.
  - 1010–1111: illegal. No write, and `erro` pulses.
- Outside DECODIFICA, `endereco_reg1/2` hold `ir[7:4]`/`ir[3:0]`. Their value is don't-care for the bank.
- Outside ESCREVE, `enable=0`. `endereco_escrita` and `conteudo_escrita` hold their last values.
- Hazards
  - Operands are read in DECODIFICA, before the instruction's own write-back, so `dest==src` reads the old value.
  - The next instruction's DECODIFICA always follows the previous write edge, so it sees the new value. No forwarding is needed.

## Timing
- Reset values (asynchronous, effective immediately):
  - state=OCIOSO and `instr_ready=1`.
  - `enable=0`, `concluido=0`, `erro=0`.
  - `ir=0`, `op_a=0`, `op_b=0`, `resultado=0`.
  - All address and data outputs are 0.
  - `instr_executadas=0`.
- The unit never captures while `rst=1`.
- Instruction accepted at edge E0:
  - DECODIFICA during cycle E0–E1.
  - EXECUTA during cycle E1–E2.
  - ESCREVE during cycle E2–E3, with `enable` high in this cycle only.
  - The bank stores the result at edge E3.
- `instr_ready` rises after E3. The earliest next acceptance is E4.
- Throughput is one instruction per 4 cycles. Latency is uniform for every opcode, including NOP and illegal opcodes.
- If `instr_valid` is held high, back-to-back instructions are accepted every 4th edge. `instrucao` changes while not ready are ignored.
- Reset mid-instruction aborts it:
  - No write occurs, even if asserted during ESCREVE, because `enable` drops asynchronously.
  - `concluido` is not asserted.
  - The counter clears.
- `instr_executadas` wraps 255→0 and counts NOP and illegal instructions.

## Test plan
- Reset mid-ESCREVE of ADD r1: `enable` falls immediately, r1 is unchanged, and `instr_ready=1` in the next cycle with counter=0.
- After reset, LDI r3,0x5A accepted at E0 → `enable=1` only during cycle E2–E3 with addr=3 and data=0x005A. `concluido` pulses, the counter becomes 1, and `instr_ready` returns after E3.
- With the bank model preloaded r1=0xFFFF, r2=0x0002: ADD r4,r1,r2 → write 0x0001 to r4. SUB r5,r2,r1 → write 0x0003.
- Back-to-back with valid held high: LDI r1,0x07; ADDI r1,r1,3; SHL r2,r1,4 → r1=0x0007, then 0x000A, then r2=0x00A0. Acceptances land exactly 4 edges apart.
- Opcode 0xC followed by NOP → no `enable` for either. `erro` pulses only for the 0xC instruction, `concluido` pulses for both, and the counter advances by 2.
- Issue 256 NOPs → the counter reads 0x00 after the 256th retirement and never asserts `enable`.

Source files
------------

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle initiator for the 16x16 register bank.
// Each instruction takes four cycles: accept, operand fetch, ALU execute, write-back.
module unidade_controle (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instrucao,
    output logic        instr_ready,
    output logic [3:0]  endereco_reg1,
    output logic [3:0]  endereco_reg2,
    input  logic [15:0] conteudo_reg1,
    input  logic [15:0] conteudo_reg2,
    output logic        enable,
    output logic [3:0]  endereco_escrita,
    output logic [15:0] conteudo_escrita,
    output logic        concluido,
    output logic        erro,
    output logic [7:0]  instr_executadas
);

    typedef enum logic [1:0] {
        OCIOSO     = 2'd0,
        DECODIFICA = 2'd1,
        EXECUTA    = 2'd2,
        ESCREVE    = 2'd3
    } estado_t;

    estado_t     estado_r;
    estado_t     estado_s;
    logic [15:0] ir_r;
    logic [15:0] op_a_r;
    logic [15:0] op_b_r;
    logic [15:0] resultado_r;
    logic        escreve_r;
    logic        ilegal_r;
    logic [3:0]  end_escrita_r;
    logic [7:0]  contador_r;
    logic [15:0] resultado_s;
    logic        escreve_s;
    logic        ilegal_s;

    // ALU: result and write/illegal flags from the latched operands and instruction
    always_comb begin
        resultado_s = 16'h0000;
        escreve_s   = 1'b1;
        ilegal_s    = 1'b0;
        case (ir_r[15:12])
            4'h0:    escreve_s   = 1'b0;
            4'h1:    resultado_s = op_a_r + op_b_r;
            4'h2:    resultado_s = op_a_r - op_b_r;
            4'h3:    resultado_s = op_a_r & op_b_r;
            4'h4:    resultado_s = op_a_r | op_b_r;
            4'h5:    resultado_s = op_a_r ^ op_b_r;
            4'h6:    resultado_s = {8'h00, ir_r[7:0]};
            4'h7:    resultado_s = op_a_r + {12'h000, ir_r[3:0]};
            4'h8:    resultado_s = op_a_r << ir_r[3:0];
            4'h9:    resultado_s = op_a_r >> ir_r[3:0];
            default: begin
                escreve_s = 1'b0;
                ilegal_s  = 1'b1;
            end
        endcase
    end

    // Next-state logic: fixed four-state ring, only OCIOSO waits on the handshake
    always_comb begin
        estado_s = estado_r;
        case (estado_r)
            OCIOSO: begin
                if (instr_valid) begin
                    estado_s = DECODIFICA;
                end else begin
                    estado_s = OCIOSO;
                end
            end
            DECODIFICA: estado_s = EXECUTA;
            EXECUTA:    estado_s = ESCREVE;
            ESCREVE:    estado_s = OCIOSO;
            default:    estado_s = OCIOSO;
        endcase
    end

    // State and datapath registers; each stage captures only in its own state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_r      <= OCIOSO;
            ir_r          <= 16'h0000;
            op_a_r        <= 16'h0000;
            op_b_r        <= 16'h0000;
            resultado_r   <= 16'h0000;
            escreve_r     <= 1'b0;
            ilegal_r      <= 1'b0;
            end_escrita_r <= 4'h0;
            contador_r    <= 8'h00;
        end else begin
            estado_r <= estado_s;
            case (estado_r)
                OCIOSO: begin
                    if (instr_valid) begin
                        ir_r <= instrucao;
                    end
                end
                DECODIFICA: begin
                    op_a_r <= conteudo_reg1;
                    op_b_r <= conteudo_reg2;
                end
                EXECUTA: begin
                    resultado_r   <= resultado_s;
                    escreve_r     <= escreve_s;
                    ilegal_r      <= ilegal_s;
                    end_escrita_r <= ir_r[11:8];
                end
                ESCREVE: begin
                    contador_r <= contador_r + 8'd1;
                end
                default: begin
                    contador_r <= contador_r;
                end
            endcase
        end
    end

    // Strobes decode from the state register so a reset clears them without waiting for a clock edge
    assign instr_ready      = (estado_r == OCIOSO);
    assign enable           = (estado_r == ESCREVE) && escreve_r;
    assign concluido        = (estado_r == ESCREVE);
    assign erro             = (estado_r == ESCREVE) && ilegal_r;
    assign endereco_reg1    = ir_r[7:4];
    assign endereco_reg2    = ir_r[3:0];
    assign endereco_escrita = end_escrita_r;
    assign conteudo_escrita = resultado_r;
    assign instr_executadas = contador_r;

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: register-bank model, cycle-level behavioural reference,
// directed scenarios and randomized instruction traffic.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [15:0] instrucao;
    logic        instr_ready;
    logic [3:0]  endereco_reg1;
    logic [3:0]  endereco_reg2;
    logic [15:0] conteudo_reg1;
    logic [15:0] conteudo_reg2;
    logic        enable;
    logic [3:0]  endereco_escrita;
    logic [15:0] conteudo_escrita;
    logic        concluido;
    logic        erro;
    logic [7:0]  instr_executadas;

    int checks   = 0;
    int failures = 0;

    logic [15:0] bank [16];
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = 4'h0;
    logic [15:0] pre_data = 16'h0000;

    int          m_cnt = 0;
    int          m_count = 0;
    int          cyc = 0;
    logic [15:0] m_ir = 16'h0000;
    int          m_res = 0;
    bit          m_wr = 1'b0;
    bit          m_ill = 1'b0;
    int          acc_q [$];
    bit          chk_en = 1'b0;
    int          n_en = 0;
    int          n_conc = 0;
    int          n_erro = 0;

    always #5 clk = ~clk;

    unidade_controle dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instrucao(instrucao),
        .instr_ready(instr_ready), .endereco_reg1(endereco_reg1), .endereco_reg2(endereco_reg2),
        .conteudo_reg1(conteudo_reg1), .conteudo_reg2(conteudo_reg2), .enable(enable),
        .endereco_escrita(endereco_escrita), .conteudo_escrita(conteudo_escrita),
        .concluido(concluido), .erro(erro), .instr_executadas(instr_executadas)
    );

    // Register bank: asynchronous reads, synchronous write, plus a preload path
    assign conteudo_reg1 = bank[endereco_reg1];
    assign conteudo_reg2 = bank[endereco_reg2];
    always @(posedge clk) begin
        if (enable) bank[endereco_escrita] <= conteudo_escrita;
        else if (pre_we) bank[pre_addr] <= pre_data;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_res(input logic [15:0] ir, input longint a, input longint b);
        int op;
        longint imm;
        op  = int'(ir[15:12]);
        imm = longint'(ir[3:0]);
        case (op)
            1: return int'((a + b) % 65536);
            2: return int'((a - b + 65536) % 65536);
            3: return int'(a & b);
            4: return int'(a | b);
            5: return int'(a ^ b);
            6: return int'(ir[7:0]);
            7: return int'((a + imm) % 65536);
            8: return int'((a * (64'd1 << imm)) % 65536);
            9: return int'(a / (64'd1 << imm));
            default: return 0;
        endcase
    endfunction

    // Reference: an accepted instruction occupies the unit for 4 cycles, retiring in the 4th
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt   <= 0;
            m_count <= 0;
        end else begin
            cyc <= cyc + 1;
            if (m_cnt == 0) begin
                if (instr_valid) begin
                    m_ir  <= instrucao;
                    m_res <= exp_res(instrucao, longint'(bank[instrucao[7:4]]), longint'(bank[instrucao[3:0]]));
                    m_wr  <= (instrucao[15:12] != 4'h0) && (instrucao[15:12] < 4'hA);
                    m_ill <= (instrucao[15:12] >= 4'hA);
                    m_cnt <= 1;
                    acc_q.push_back(cyc);
                end
            end else if (m_cnt == 3) begin
                m_cnt   <= 0;
                m_count <= (m_count + 1) % 256;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Per-cycle comparison against the reference
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            if (enable) n_en++;
            if (concluido) n_conc++;
            if (erro) n_erro++;
            chk("instr_ready", instr_ready, m_cnt == 0);
            chk("enable", enable, (m_cnt == 3) && m_wr);
            chk("concluido", concluido, m_cnt == 3);
            chk("erro", erro, (m_cnt == 3) && m_ill);
            chk("instr_executadas", instr_executadas, m_count);
            if (m_cnt == 1) begin
                chk("endereco_reg1", endereco_reg1, m_ir[7:4]);
                chk("endereco_reg2", endereco_reg2, m_ir[3:0]);
            end
            if (m_cnt == 3) begin
                chk("endereco_escrita", endereco_escrita, m_ir[11:8]);
                if (m_wr) chk("conteudo_escrita", conteudo_escrita, m_res);
            end
        end
    end

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Offers one instruction when idle; returns at the negedge inside DECODIFICA
    task automatic drive(input logic [15:0] ins);
        for (int i = 0; i < 8 && !instr_ready; i++) @(negedge clk);
        chk("drive_ready_timeout", instr_ready, 1'b1);
        instr_valid = 1'b1;
        instrucao   = ins;
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic run_one(input logic [15:0] ins);
        drive(ins);
        repeat (3) @(negedge clk);
    endtask

    logic [15:0] seq [3];
    int c0, e0, en0, k0;

    initial begin
        rst = 1'b1;
        instr_valid = 1'b0;
        instrucao = 16'h0000;
        for (int r = 0; r < 16; r++) preload(r[3:0], 16'($urandom));
        chk("rst_ready", instr_ready, 1'b1);
        chk("rst_enable", enable, 1'b0);
        chk("rst_concluido", concluido, 1'b0);
        chk("rst_erro", erro, 1'b0);
        chk("rst_addr1", endereco_reg1, 4'h0);
        chk("rst_addr2", endereco_reg2, 4'h0);
        chk("rst_waddr", endereco_escrita, 4'h0);
        chk("rst_wdata", conteudo_escrita, 16'h0000);
        chk("rst_count", instr_executadas, 8'h00);
        rst = 1'b0;
        chk_en = 1'b1;

        // LDI r3,0x5A with explicit write-cycle literals
        drive(16'h635A);
        chk("ldi_decod_enable", enable, 1'b0);
        @(negedge clk);
        chk("ldi_exec_enable", enable, 1'b0);
        @(negedge clk);
        chk("ldi_wr_enable", enable, 1'b1);
        chk("ldi_wr_addr", endereco_escrita, 4'h3);
        chk("ldi_wr_data", conteudo_escrita, 16'h005A);
        @(negedge clk);
        chk("ldi_after_enable", enable, 1'b0);
        chk("ldi_after_ready", instr_ready, 1'b1);
        chk("ldi_bank_r3", bank[3], 16'h005A);
        chk("ldi_count", instr_executadas, 8'h01);

        // Reset while in ESCREVE of ADD r1 aborts the write
        preload(4'h1, 16'h1234);
        preload(4'h2, 16'h0001);
        preload(4'h3, 16'h0001);
        drive(16'h1123);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_enable", enable, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_enable_drop", enable, 1'b0);
        chk("abort_concluido", concluido, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        chk("abort_ready", instr_ready, 1'b1);
        chk("abort_count", instr_executadas, 8'h00);
        chk("abort_bank_r1", bank[1], 16'h1234);

        // ADD / SUB with wrap-around
        preload(4'h1, 16'hFFFF);
        preload(4'h2, 16'h0002);
        run_one(16'h1412);
        chk("add_r4", bank[4], 16'h0001);
        run_one(16'h2521);
        chk("sub_r5", bank[5], 16'h0003);

        // Back-to-back with instr_valid held high; garbage while busy must be ignored
        seq[0] = 16'h6107;
        seq[1] = 16'h7113;
        seq[2] = 16'h8214;
        acc_q.delete();
        @(negedge clk);
        instr_valid = 1'b1;
        instrucao = seq[0];
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            instrucao = 16'($urandom);
            repeat (3) @(negedge clk);
            if (k == 1) chk("b2b_r1_first", bank[1], 16'h0007);
            if (k < 3) instrucao = seq[k];
            else instr_valid = 1'b0;
        end
        chk("b2b_r1", bank[1], 16'h000A);
        chk("b2b_r2", bank[2], 16'h00A0);
        chk("b2b_accepts", acc_q.size(), 3);
        if (acc_q.size() == 3) begin
            chk("b2b_gap1", acc_q[1] - acc_q[0], 4);
            chk("b2b_gap2", acc_q[2] - acc_q[1], 4);
        end

        // Illegal opcode then NOP
        c0 = m_count;
        e0 = n_erro;
        k0 = n_conc;
        en0 = n_en;
        run_one(16'hC123);
        run_one(16'h0456);
        chk("ill_count", instr_executadas, (c0 + 2) % 256);
        chk("ill_erro_pulses", n_erro - e0, 1);
        chk("ill_conc_pulses", n_conc - k0, 2);
        chk("ill_no_enable", n_en - en0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            instr_valid = 1'($urandom_range(0, 1));
            instrucao = 16'($urandom);
        end
        instr_valid = 1'b0;
        repeat (6) @(negedge clk);

        // 256 NOPs from a cleared counter wrap it back to zero
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en0 = n_en;
        k0 = n_conc;
        for (int i = 0; i < 256; i++) run_one(16'h0123);
        chk("nop_wrap_count", instr_executadas, 8'h00);
        chk("nop_no_enable", n_en - en0, 0);
        chk("nop_conc_pulses", n_conc - k0, 256);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
